// File: rtl/int_to_float.sv
// int_to_float: sequential signed-integer to IEEE-754 binary32 encoder.
//
// Accepts a 32-bit two's-complement integer over a ready/valid handshake,
// normalizes its magnitude one bit per cycle, then applies
// round-to-nearest-even. The result is presented on a second
// ready/valid handshake. Accept and output never overlap: a new input
// is taken only after the previous result has been consumed.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   in_int is valid
//   in_ready   block can accept an input (high only while idle)
//   in_int     signed two's-complement integer (INT_W bits)
//   out_valid  out_result is valid
//   out_ready  consumer accepts out_result
//   out_result IEEE-754 word {sign, exp[7:0], frac[22:0]}
//
// Only XLEN = 32 and INT_W = 32 are supported.

module int_to_float #(
  parameter int XLEN  = 32,
  parameter int INT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] in_int,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result
);

  // Biased exponent of a value whose leading one sits at bit INT_W-1.
  localparam logic [7:0] EXP_SEED = 8'(127 + INT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t            state, state_d;
  logic [INT_W-1:0]  mag, mag_d;
  logic [7:0]        exp_q, exp_d;
  logic              sign, sign_d;
  logic [XLEN-1:0]   result_d;

  // Rounding terms, only meaningful in ROUND (mag is normalized there).
  logic              lsb, guard, sticky, round_up;
  logic [24:0]       m24;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign lsb      = mag[8];
  assign guard    = mag[7];
  assign sticky   = |mag[6:0];
  assign round_up = guard && (sticky || lsb);
  // Extra top bit catches the carry when 24 ones round up.
  assign m24      = {1'b0, mag[31:8]} + {24'd0, round_up};

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state;
    mag_d    = mag;
    exp_d    = exp_q;
    sign_d   = sign;
    result_d = out_result;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_int[INT_W-1];
          // Unsigned wrap makes -2^31 come out as 0x80000000.
          mag_d  = in_int[INT_W-1] ? ('0 - in_int) : in_int;
          exp_d  = EXP_SEED;
          if (in_int == '0) begin
            // Zero has no leading one to find; emit +0 directly.
            result_d = '0;
            state_d  = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end

      NORM: begin
        if (mag[INT_W-1]) begin
          state_d = ROUND;
        end else begin
          mag_d = {mag[INT_W-2:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end

      ROUND: begin
        if (m24[24]) begin
          // Mantissa overflowed to 2.0: renormalize by bumping exponent.
          result_d = {sign, exp_q + 8'd1, 23'd0};
        end else begin
          result_d = {sign, exp_q, m24[22:0]};
        end
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the values from before this edge, independent of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mag        <= '0;
      exp_q      <= '0;
      sign       <= 1'b0;
      out_result <= '0;
    end else begin
      state      <= state_d;
      mag        <= mag_d;
      exp_q      <= exp_d;
      sign       <= sign_d;
      out_result <= result_d;
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// Testbench for int_to_float: directed cases plus randomized inputs
// compared against an arithmetic reference model of int -> binary32.

module tb_int_to_float;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_int;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int n_checks = 0;
  int n_pass   = 0;

  int_to_float #(.XLEN(32), .INT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_int     (in_int),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference: round |x| to 24 significant bits with ties-to-even using
  // plain integer arithmetic on the exact remainder.
  function automatic logic [31:0] ref_float(input logic [31:0] x, output int e);
    longint v, m, q, rem, half;
    int sh;
    logic s;
    v = longint'($signed(x));
    e = 0;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? -v : v;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {s, 8'(127 + e), q[22:0]};
  endfunction

  // Accept one input, wait for the result, then consume it.
  // lat = edges after the accept edge until out_valid is seen high.
  task automatic convert(input logic [31:0] val, output logic [31:0] res, output int lat);
    int waited;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_int   = val;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    res = out_result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] val;
    logic [31:0] exp_res;
    int          exp_lat;
    string       tag;
  } dir_t;

  initial begin
    dir_t        dirs[8];
    logic [31:0] res, held, x, r;
    int          lat, e, rises;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_int    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_in_ready",   32'(in_ready),  32'd1);
    check("rst_out_valid",  32'(out_valid), 32'd0);
    check("rst_out_result", out_result,     32'h0);

    // Latency: lz + 2 edges for nonzero; zero is valid right after the
    // accept edge itself.
    dirs[0] = '{32'd3,          32'h40400000, 32, "pos3"};
    dirs[1] = '{-32'sd6,        32'hC0C00000, 31, "neg6"};
    dirs[2] = '{32'd1,          32'h3F800000, 33, "one"};
    dirs[3] = '{32'd0,          32'h00000000, 0,  "zero"};
    dirs[4] = '{32'd16777217,   32'h4B800000, 9,  "tie_even_down"};
    dirs[5] = '{32'd16777219,   32'h4B800002, 9,  "tie_up"};
    dirs[6] = '{32'd2147483647, 32'h4F000000, 3,  "carry_out"};
    dirs[7] = '{32'h80000000,   32'hCF000000, 2,  "int_min"};

    foreach (dirs[i]) begin
      convert(dirs[i].val, res, lat);
      check({dirs[i].tag, "_res"}, res, dirs[i].exp_res);
      check({dirs[i].tag, "_lat"}, 32'(lat), 32'(dirs[i].exp_lat));
    end

    // Backpressure: hold the result, offer a new input meanwhile.
    in_valid = 1'b1;
    in_int   = 32'd5;
    @(posedge clk); #1;
    in_int = 32'd7;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_valid", 32'(out_valid), 32'd1);
    held = out_result;
    check("bp_res", held, 32'h40A00000);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_hold",      out_result,      held);
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),   32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_ready", 32'(in_ready),  32'd1);
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    convert(32'd3, res, lat);
    check("bp_next_res", res, 32'h40400000);

    // Reset during NORM drops the conversion of 1.
    rises = 0;
    in_valid = 1'b1;
    in_int   = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) rises++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (40) begin
      if (out_valid) rises++;
      @(posedge clk); #1;
    end
    check("mid_rst_no_valid", 32'(rises), 32'd0);
    convert(32'd3, res, lat);
    check("mid_rst_next", res, 32'h40400000);

    // Randomized values over a spread of magnitudes and both signs.
    for (int k = 0; k < 200; k++) begin
      x = $urandom >> $urandom_range(31, 0);
      if ($urandom_range(1, 0) == 1) x = -x;
      r = ref_float(x, e);
      convert(x, res, lat);
      check($sformatf("rand_res_%08h", x), res, r);
      if (x != 0) check($sformatf("rand_lat_%08h", x), 32'(lat), 32'((31 - e) + 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
